// File: rtl/ub_ctrl_pkg.sv
// Shared types and elaboration helpers for the unified-buffer port controllers.
// A port controller walks a 3-deep loop nest and fires its enable on an affine schedule.
package ub_ctrl_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_CYCLE_W = 32;
  localparam int unsigned NUM_LEVELS  = 3;

  typedef logic [DEF_CYCLE_W-1:0]           cycle_t;
  typedef logic [NUM_LEVELS-1:0][DEF_WIDTH-1:0] ctrl_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  // Cycles covered by one full sweep of a level: (extent-1)*stride.
  function automatic logic [63:0] span(input logic [63:0] extent, input logic [63:0] stride);
    return (extent - 64'd1) * stride;
  endfunction

  function automatic bit fits(input int unsigned width, input logic [63:0] value);
    return (width >= 64) || ((value >> width) == 64'd0);
  endfunction

endpackage

// File: rtl/ub_loop_level_counter.sv
// One level of the loop nest: a wrapping counter that advances on inc and flags
// its final value so the level above can be carried into.
module ub_loop_level_counter
  import ub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] extent,
  output logic [WIDTH-1:0] value,
  output logic             last
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  assign last  = (value_q == (extent - WIDTH'(1)));
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc) begin
      value_d = last ? '0 : (value_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/ub_affine_loop_ctrl.sv
// Schedule-driven port controller for a unified buffer: emits valid (wen/ren) and
// the iteration vector, issuing vector v at SCHED_OFFSET + sum(STRIDEi*vi) plus stalls.
module ub_affine_loop_ctrl
  import ub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned CYCLE_W      = DEF_CYCLE_W,
  parameter int unsigned EXT0         = 1,
  parameter int unsigned EXT1         = 62,
  parameter int unsigned EXT2         = 62,
  parameter int unsigned SCHED_OFFSET = 0,
  parameter int unsigned STRIDE0      = 4096,
  parameter int unsigned STRIDE1      = 64,
  parameter int unsigned STRIDE2      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  en,
  output logic                  valid,
  output logic [2:0][WIDTH-1:0] ctrl_vars,
  output logic                  done
);

  localparam logic [63:0] SPAN0 = span(64'(EXT0), 64'(STRIDE0));
  localparam logic [63:0] SPAN1 = span(64'(EXT1), 64'(STRIDE1));
  localparam logic [63:0] SPAN2 = span(64'(EXT2), 64'(STRIDE2));

  // Step from one issue time to the next depends only on which levels wrap.
  localparam logic [63:0] DELTA2_L    = 64'(STRIDE2);
  localparam logic [63:0] DELTA1_L    = 64'(STRIDE1) - SPAN2;
  localparam logic [63:0] DELTA0_L    = 64'(STRIDE0) - SPAN1 - SPAN2;
  localparam logic [63:0] LAST_TIME_L = 64'(SCHED_OFFSET) + SPAN0 + SPAN1 + SPAN2;

  localparam logic [CYCLE_W-1:0] DELTA2   = DELTA2_L[CYCLE_W-1:0];
  localparam logic [CYCLE_W-1:0] DELTA1   = DELTA1_L[CYCLE_W-1:0];
  localparam logic [CYCLE_W-1:0] DELTA0   = DELTA0_L[CYCLE_W-1:0];
  localparam logic [CYCLE_W-1:0] OFFSET_C = CYCLE_W'(SCHED_OFFSET);

  if (CYCLE_W == 0 || CYCLE_W > 64) begin : g_bad_cycle_w
    $error("ub_affine_loop_ctrl: CYCLE_W must be in 1..64");
  end
  if (WIDTH == 0) begin : g_bad_width
    $error("ub_affine_loop_ctrl: WIDTH must be at least 1");
  end
  if (EXT0 == 0 || EXT1 == 0 || EXT2 == 0) begin : g_bad_extent
    $error("ub_affine_loop_ctrl: every loop extent must be at least 1");
  end
  if (STRIDE2 == 0) begin : g_bad_stride2
    $error("ub_affine_loop_ctrl: STRIDE2 must be at least 1");
  end
  if (64'(STRIDE1) <= SPAN2) begin : g_bad_stride1
    $error("ub_affine_loop_ctrl: STRIDE1 must exceed (EXT2-1)*STRIDE2");
  end
  if (64'(STRIDE0) <= (SPAN1 + SPAN2)) begin : g_bad_stride0
    $error("ub_affine_loop_ctrl: STRIDE0 must exceed (EXT1-1)*STRIDE1 + (EXT2-1)*STRIDE2");
  end
  if (!fits(CYCLE_W, LAST_TIME_L)) begin : g_bad_last_time
    $error("ub_affine_loop_ctrl: last issue time does not fit in CYCLE_W");
  end
  if (!fits(WIDTH, 64'(EXT0) - 64'd1) || !fits(WIDTH, 64'(EXT1) - 64'd1) ||
      !fits(WIDTH, 64'(EXT2) - 64'd1)) begin : g_bad_var_width
    $error("ub_affine_loop_ctrl: WIDTH cannot hold EXT-1 for some level");
  end

  ctrl_state_e        state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [CYCLE_W-1:0] next_time_q, next_time_d;
  logic [CYCLE_W-1:0] step;

  logic             inc0, inc1, inc2;
  logic             last0, last1, last2;
  logic             final_iter;
  logic             advance;
  logic [WIDTH-1:0] value0, value1, value2;

  ub_loop_level_counter #(.WIDTH(WIDTH)) u_level0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flush),
    .inc    (inc0),
    .extent (WIDTH'(EXT0)),
    .value  (value0),
    .last   (last0)
  );

  ub_loop_level_counter #(.WIDTH(WIDTH)) u_level1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flush),
    .inc    (inc1),
    .extent (WIDTH'(EXT1)),
    .value  (value1),
    .last   (last1)
  );

  ub_loop_level_counter #(.WIDTH(WIDTH)) u_level2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flush),
    .inc    (inc2),
    .extent (WIDTH'(EXT2)),
    .value  (value2),
    .last   (last2)
  );

  assign ctrl_vars  = {value2, value1, value0};
  assign final_iter = last0 & last1 & last2;

  // The final vector never advances, so DONE holds the last issued iteration.
  always_comb begin
    advance = valid & ~final_iter;
    inc2    = advance;
    inc1    = advance & last2;
    inc0    = advance & last2 & last1;
    if (!last2) begin
      step = DELTA2;
    end else if (!last1) begin
      step = DELTA1;
    end else begin
      step = DELTA0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    next_time_d = next_time_q;
    valid       = 1'b0;
    done        = (state_q == DONE);

    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (en) begin
          cycle_d = cycle_q + CYCLE_W'(1);
          if (cycle_q == next_time_q) begin
            valid = 1'b1;
            if (final_iter) begin
              state_d = DONE;
            end else begin
              next_time_d = next_time_q + step;
            end
          end
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase

    // A same-cycle access still shows on valid; the restart takes the edge.
    if (flush) begin
      state_d     = IDLE;
      cycle_d     = '0;
      next_time_d = OFFSET_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cycle_q     <= '0;
      next_time_q <= OFFSET_C;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      next_time_q <= next_time_d;
    end
  end

endmodule

// File: tb/tb_ub_affine_loop_ctrl.sv
// Scoreboard bench for ub_affine_loop_ctrl: expected (vector, issue cycle) pairs are
// queued from the affine formula and popped by per-instance monitors on every pulse.
module tb_ub_affine_loop_ctrl;

  localparam int W = 16;

  typedef struct {
    logic [2:0][W-1:0] vec;
    longint            t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint wall = 0;
  always @(posedge clk) wall <= wall + 1;

  int checks = 0;
  int errors = 0;

  logic              rst_n_a, flush_a, en_a, valid_a, done_a;
  logic [2:0][W-1:0] vars_a;
  logic              rst_n_bc, flush_bc, en_bc;
  logic              valid_b, done_b, valid_c, done_c;
  logic [2:0][W-1:0] vars_b, vars_c;

  exp_t   q_a[$];
  exp_t   q_b[$];
  exp_t   q_c[$];
  exp_t   ea, eb, ec;
  int     pulses_a = 0, pulses_b = 0, pulses_c = 0;
  longint first_done_a = -1, first_done_b = -1, first_done_c = -1;

  ub_affine_loop_ctrl #(.WIDTH(W), .SCHED_OFFSET(5)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n_a),
    .flush     (flush_a),
    .en        (en_a),
    .valid     (valid_a),
    .ctrl_vars (vars_a),
    .done      (done_a)
  );

  ub_affine_loop_ctrl #(.WIDTH(W), .EXT0(1), .EXT1(1), .EXT2(1), .SCHED_OFFSET(0)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n_bc),
    .flush     (flush_bc),
    .en        (en_bc),
    .valid     (valid_b),
    .ctrl_vars (vars_b),
    .done      (done_b)
  );

  ub_affine_loop_ctrl #(.WIDTH(W), .EXT0(2), .EXT1(2), .EXT2(3), .SCHED_OFFSET(2),
                        .STRIDE0(20), .STRIDE1(4), .STRIDE2(1)) dut_c (
    .clk       (clk),
    .rst_n     (rst_n_bc),
    .flush     (flush_bc),
    .en        (en_bc),
    .valid     (valid_c),
    .ctrl_vars (vars_c),
    .done      (done_c)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue cycle of each vector comes straight from the affine formula, shifted by any stall.
  task automatic push_run(input int id, input longint base, input int e0, input int e1, input int e2,
                          input int s0, input int s1, input int s2, input int off,
                          input longint limit, input longint stall_at, input longint stall_len,
                          output int n);
    exp_t   e;
    longint t;
    n = 0;
    for (int v0 = 0; v0 < e0; v0++) begin
      for (int v1 = 0; v1 < e1; v1++) begin
        for (int v2 = 0; v2 < e2; v2++) begin
          t = longint'(off) + longint'(s0) * v0 + longint'(s1) * v1 + longint'(s2) * v2;
          if (t <= limit) begin
            e.vec[0] = W'(v0);
            e.vec[1] = W'(v1);
            e.vec[2] = W'(v2);
            e.t      = base + t + ((t >= stall_at) ? stall_len : 0);
            case (id)
              0:       q_a.push_back(e);
              1:       q_b.push_back(e);
              default: q_c.push_back(e);
            endcase
            n++;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (valid_a) begin
      pulses_a++;
      if (q_a.size() == 0) begin
        checkOutput("A unexpected pulse", 64'(wall), 64'(-1));
      end else begin
        ea = q_a.pop_front();
        checkOutput("A vector", 64'(vars_a), 64'(ea.vec));
        checkOutput("A issue cycle", 64'(wall), 64'(ea.t));
      end
    end
    if (done_a && first_done_a < 0) first_done_a = wall;

    if (valid_b) begin
      pulses_b++;
      if (q_b.size() == 0) begin
        checkOutput("B unexpected pulse", 64'(wall), 64'(-1));
      end else begin
        eb = q_b.pop_front();
        checkOutput("B vector", 64'(vars_b), 64'(eb.vec));
        checkOutput("B issue cycle", 64'(wall), 64'(eb.t));
      end
    end
    if (done_b && first_done_b < 0) first_done_b = wall;

    if (valid_c) begin
      pulses_c++;
      if (q_c.size() == 0) begin
        checkOutput("C unexpected pulse", 64'(wall), 64'(-1));
      end else begin
        ec = q_c.pop_front();
        checkOutput("C vector", 64'(vars_c), 64'(ec.vec));
        checkOutput("C issue cycle", 64'(wall), 64'(ec.t));
      end
    end
    if (done_c && first_done_c < 0) first_done_c = wall;
  end

  task automatic clear_a_stats();
    pulses_a     = 0;
    first_done_a = -1;
  endtask

  task automatic wait_done_a(input string tag, input longint exp_done, input int n_exp);
    for (int i = 0; i < 4200; i++) begin
      wait_cycles(1);
      if (done_a) break;
    end
    wait_cycles(2);
    checkOutput({tag, " done cycle"}, 64'(first_done_a), 64'(exp_done));
    checkOutput({tag, " pulse count"}, 64'(pulses_a), 64'(n_exp));
    checkOutput({tag, " queue drained"}, 64'(q_a.size()), 64'd0);
    checkOutput({tag, " last vector held"}, 64'(vars_a), {16'd0, 16'd61, 16'd61, 16'd0});
  endtask

  task automatic applyStimulus();
    longint base, base2;
    int     n;

    rst_n_a  = 1'b0; flush_a  = 1'b0; en_a  = 1'b1;
    rst_n_bc = 1'b0; flush_bc = 1'b0; en_bc = 1'b1;
    wait_cycles(3);
    checkOutput("A reset valid", 64'(valid_a), 64'd0);
    checkOutput("A reset done", 64'(done_a), 64'd0);
    checkOutput("A reset vars", 64'(vars_a), 64'd0);
    checkOutput("C reset valid", 64'(valid_c), 64'd0);

    $display("[TB] full default schedule");
    rst_n_a = 1'b1;
    base = wall + 1;
    clear_a_stats();
    push_run(0, base, 1, 62, 62, 4096, 64, 1, 5, 64'sd1 << 40, 64'sd1 << 40, 0, n);
    checkOutput("A expected pulse total", 64'(n), 64'd3844);
    wait_done_a("A run", base + 3971, n);

    $display("[TB] ten-cycle stall from schedule cycle 30");
    flush_a = 1'b1;
    base = wall + 2;
    wait_cycles(1);
    flush_a = 1'b0;
    clear_a_stats();
    push_run(0, base, 1, 62, 62, 4096, 64, 1, 5, 64'sd1 << 40, 30, 10, n);
    wait_cycles(31);
    en_a = 1'b0;
    wait_cycles(10);
    en_a = 1'b1;
    wait_done_a("A stall", base + 3981, n);

    $display("[TB] flush during schedule cycle 200");
    flush_a = 1'b1;
    base = wall + 2;
    wait_cycles(1);
    flush_a = 1'b0;
    clear_a_stats();
    push_run(0, base, 1, 62, 62, 4096, 64, 1, 5, 200, 64'sd1 << 40, 0, n);
    wait_cycles(201);
    flush_a = 1'b1;
    base2 = wall + 2;
    wait_cycles(1);
    flush_a = 1'b0;
    checkOutput("A pulses before flush", 64'(pulses_a), 64'(n));
    checkOutput("A queue at flush", 64'(q_a.size()), 64'd0);
    checkOutput("A vars cleared by flush", 64'(vars_a), 64'd0);

    $display("[TB] asynchronous reset at schedule cycle 1000");
    clear_a_stats();
    push_run(0, base2, 1, 62, 62, 4096, 64, 1, 5, 999, 64'sd1 << 40, 0, n);
    wait_cycles(1001);
    #1;
    checkOutput("A pulse live at 1000", 64'(valid_a), 64'd1);
    checkOutput("A vector at 1000", 64'(vars_a), {16'd0, 16'd35, 16'd15, 16'd0});
    #1;
    rst_n_a = 1'b0;
    #1;
    checkOutput("A async reset valid", 64'(valid_a), 64'd0);
    checkOutput("A async reset done", 64'(done_a), 64'd0);
    checkOutput("A async reset vars", 64'(vars_a), 64'd0);
    checkOutput("A pulses before reset", 64'(pulses_a), 64'(n));
    checkOutput("A queue at reset", 64'(q_a.size()), 64'd0);
    wait_cycles(1);
    rst_n_a = 1'b1;
    base = wall + 1;
    clear_a_stats();
    push_run(0, base, 1, 62, 62, 4096, 64, 1, 5, 64'sd1 << 40, 64'sd1 << 40, 0, n);
    wait_done_a("A after reset", base + 3971, n);

    $display("[TB] single-iteration and small nests");
    rst_n_bc = 1'b1;
    base = wall + 1;
    push_run(1, base, 1, 1, 1, 4096, 64, 1, 0, 64'sd1 << 40, 64'sd1 << 40, 0, n);
    push_run(2, base, 2, 2, 3, 20, 4, 1, 2, 64'sd1 << 40, 64'sd1 << 40, 0, n);
    wait_cycles(101);
    checkOutput("B done cycle", 64'(first_done_b), 64'(base + 1));
    checkOutput("B pulse count", 64'(pulses_b), 64'd1);
    checkOutput("B done held", 64'(done_b), 64'd1);
    checkOutput("C done cycle", 64'(first_done_c), 64'(base + 29));
    checkOutput("C pulse count", 64'(pulses_c), 64'd12);
    checkOutput("C queue drained", 64'(q_c.size()), 64'd0);
    checkOutput("C last vector held", 64'(vars_c), {16'd0, 16'd2, 16'd1, 16'd1});
  endtask

  initial begin
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
